// File: rtl/game_ctl.sv
// rtl/game_ctl.sv - Duck Hunt game sequencer: duck launch, shots, hits, rounds, fly-away timeout, score
module game_ctl #(
    parameter int DUCKS_PER_ROUND = 10,
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int HITS_TO_PASS    = 6,
    parameter int FLY_FRAMES      = 300,
    parameter int PAUSE_FRAMES    = 60,
    parameter int HIT_POINTS      = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic        start,
    input  logic        trigger,
    input  logic        duck_hit,
    input  logic        duck_offscreen,
    output logic        duck_launch,
    output logic        duck_fly_away,
    output logic        duck_falling,
    output logic [1:0]  shots_left,
    output logic [3:0]  duck_idx,
    output logic [3:0]  hits,
    output logic [3:0]  round_no,
    output logic [15:0] score,
    output logic        game_over
);
    localparam int FMAX = (FLY_FRAMES > PAUSE_FRAMES) ? FLY_FRAMES : PAUSE_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, FLY, FALL, ESCAPE, NEXT, ROUND_END, GAME_OVER
    } state_t;

    state_t        state, state_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic [1:0]    shots_n;
    logic [3:0]    idx_n, hits_n, round_n;
    logic [15:0]   score_n;
    logic [16:0]   score_sum;

    assign score_sum = {1'b0, score} + 17'(HIT_POINTS);

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        shots_n = shots_left;
        idx_n   = duck_idx;
        hits_n  = hits;
        round_n = round_no;
        score_n = score;
        case (state)
            IDLE: begin
                if (start) begin
                    score_n = '0;
                    hits_n  = '0;
                    idx_n   = '0;
                    round_n = 4'd1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: state_n = FLY;
            FLY: begin
                if (duck_hit) begin
                    hits_n  = (hits == 4'hF) ? hits : hits + 4'd1;
                    score_n = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    if (trigger && shots_left != 2'd0)
                        shots_n = shots_left - 2'd1;
                    state_n = FALL;
                end else if (trigger && shots_left == 2'd1) begin
                    shots_n = 2'd0;
                    state_n = ESCAPE;
                end else if (trigger && shots_left > 2'd1) begin
                    shots_n = shots_left - 2'd1;
                end else if (new_frame) begin
                    if (fcnt == FW'(FLY_FRAMES - 1))
                        state_n = ESCAPE;
                    else
                        fcnt_n = fcnt + 1'b1;
                end
            end
            FALL, ESCAPE: begin
                if (duck_offscreen) begin
                    state_n = NEXT;
                    fcnt_n  = '0;
                end
            end
            NEXT: begin
                if (new_frame) begin
                    if (fcnt == FW'(PAUSE_FRAMES - 1)) begin
                        if (duck_idx == 4'(DUCKS_PER_ROUND - 1)) begin
                            state_n = ROUND_END;
                            fcnt_n  = '0;
                        end else begin
                            idx_n   = duck_idx + 4'd1;
                            state_n = LAUNCH;
                        end
                    end else begin
                        fcnt_n = fcnt + 1'b1;
                    end
                end
            end
            ROUND_END: begin
                if (new_frame) begin
                    if (fcnt == FW'(PAUSE_FRAMES - 1)) begin
                        if (hits >= 4'(HITS_TO_PASS)) begin
                            round_n = (round_no == 4'hF) ? round_no : round_no + 4'd1;
                            hits_n  = '0;
                            idx_n   = '0;
                            state_n = LAUNCH;
                        end else begin
                            state_n = GAME_OVER;
                        end
                    end else begin
                        fcnt_n = fcnt + 1'b1;
                    end
                end
            end
            GAME_OVER: begin
                if (start)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Arm the duck on entry so shots_left is already valid during the launch pulse.
        if (state_n == LAUNCH) begin
            shots_n = 2'(SHOTS_PER_DUCK);
            fcnt_n  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            fcnt          <= '0;
            shots_left    <= '0;
            duck_idx      <= '0;
            hits          <= '0;
            round_no      <= 4'd1;
            score         <= '0;
            duck_launch   <= 1'b0;
            duck_fly_away <= 1'b0;
            duck_falling  <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_n;
            fcnt          <= fcnt_n;
            shots_left    <= shots_n;
            duck_idx      <= idx_n;
            hits          <= hits_n;
            round_no      <= round_n;
            score         <= score_n;
            duck_launch   <= (state_n == LAUNCH);
            duck_fly_away <= (state_n == ESCAPE);
            duck_falling  <= (state_n == FALL);
            game_over     <= (state_n == GAME_OVER);
        end
    end
endmodule

// File: tb/tb_game_ctl.sv
// tb/tb_game_ctl.sv - game_ctl bench: directed scenarios plus random play against a reference model
module tb_game_ctl;
    localparam int DUCKS = 10, SHOTS = 3, PASS = 6, FLY = 300, PAUSE = 60, PTS = 100;
    localparam int M_IDLE = 0, M_LAUNCH = 1, M_FLY = 2, M_FALL = 3, M_ESCAPE = 4,
                   M_NEXT = 5, M_ROUND_END = 6, M_OVER = 7;

    logic        clk = 1'b0;
    logic        rst, new_frame, start, trigger, duck_hit, duck_offscreen;
    logic        duck_launch, duck_fly_away, duck_falling, game_over;
    logic [1:0]  shots_left;
    logic [3:0]  duck_idx, hits, round_no;
    logic [15:0] score;

    game_ctl dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .start(start), .trigger(trigger),
        .duck_hit(duck_hit), .duck_offscreen(duck_offscreen), .duck_launch(duck_launch),
        .duck_fly_away(duck_fly_away), .duck_falling(duck_falling), .shots_left(shots_left),
        .duck_idx(duck_idx), .hits(hits), .round_no(round_no), .score(score),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int m_phase, m_frames, m_shots, m_idx, m_hits, m_round, m_score;
    bit seen_round2 = 0, seen_over = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic new_duck();
        m_phase  = M_LAUNCH;
        m_shots  = SHOTS;
        m_frames = 0;
    endtask

    // Game rules applied to the inputs seen at one clock edge.
    task automatic model_step();
        if (rst) begin
            m_phase = M_IDLE; m_frames = 0; m_shots = 0; m_idx = 0;
            m_hits = 0; m_round = 1; m_score = 0;
        end else begin
            case (m_phase)
                M_IDLE: if (start) begin
                    m_score = 0; m_hits = 0; m_idx = 0; m_round = 1;
                    new_duck();
                end
                M_LAUNCH: m_phase = M_FLY;
                M_FLY: begin
                    if (duck_hit) begin
                        m_hits  = sat(m_hits + 1, 15);
                        m_score = sat(m_score + PTS, 65535);
                        if (trigger && m_shots > 0) m_shots--;
                        m_phase = M_FALL;
                    end else if (trigger && m_shots == 1) begin
                        m_shots = 0;
                        m_phase = M_ESCAPE;
                    end else if (trigger && m_shots > 1) begin
                        m_shots--;
                    end else if (new_frame) begin
                        if (m_frames == FLY - 1) m_phase = M_ESCAPE;
                        else m_frames++;
                    end
                end
                M_FALL, M_ESCAPE: if (duck_offscreen) begin
                    m_phase = M_NEXT; m_frames = 0;
                end
                M_NEXT: if (new_frame) begin
                    if (m_frames < PAUSE - 1) m_frames++;
                    else if (m_idx == DUCKS - 1) begin m_phase = M_ROUND_END; m_frames = 0; end
                    else begin m_idx++; new_duck(); end
                end
                M_ROUND_END: if (new_frame) begin
                    if (m_frames < PAUSE - 1) m_frames++;
                    else if (m_hits >= PASS) begin
                        m_round = sat(m_round + 1, 15); m_hits = 0; m_idx = 0; new_duck();
                    end else m_phase = M_OVER;
                end
                default: if (start) m_phase = M_IDLE;
            endcase
        end
    endtask

    task automatic compare_all();
        check("duck_launch", duck_launch, int'(m_phase == M_LAUNCH));
        check("duck_fly_away", duck_fly_away, int'(m_phase == M_ESCAPE));
        check("duck_falling", duck_falling, int'(m_phase == M_FALL));
        check("game_over", game_over, int'(m_phase == M_OVER));
        check("shots_left", shots_left, m_shots);
        check("duck_idx", duck_idx, m_idx);
        check("hits", hits, m_hits);
        check("round_no", round_no, m_round);
        check("score", score, m_score);
        if (round_no == 4'd2) seen_round2 = 1;
        if (game_over) seen_over = 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic cyc(input bit nf, input bit st, input bit tr, input bit hit, input bit off);
        new_frame = nf; start = st; trigger = tr; duck_hit = hit; duck_offscreen = off;
        step();
    endtask

    // mode 0: never hit; mode 1: always hit; mode 2: unconstrained random play
    task automatic drive(input int mode);
        bit ended;
        ended = (m_phase == M_FALL || m_phase == M_ESCAPE);
        rst = 1'b0;
        case (mode)
            0: begin new_frame = 1; start = 0; trigger = 0; duck_hit = 0; duck_offscreen = ended; end
            1: begin
                new_frame = 1;
                start = (m_phase == M_IDLE || m_phase == M_OVER);
                duck_hit = (m_phase == M_FLY) && ($urandom_range(1) == 1);
                trigger = duck_hit && ($urandom_range(1) == 1);
                duck_offscreen = ended;
            end
            default: begin
                new_frame = ($urandom_range(1) == 1);
                start = ($urandom_range(15) == 0);
                trigger = ($urandom_range(5) == 0);
                duck_hit = ($urandom_range(9) == 0);
                if ($urandom_range(7) == 0) duck_offscreen = ~duck_offscreen;
                rst = ($urandom_range(2999) == 0);
            end
        endcase
        step();
    endtask

    initial begin
        rst = 1; new_frame = 0; start = 0; trigger = 0; duck_hit = 0; duck_offscreen = 0;
        step(); step();
        check("rst_round_no", round_no, 1);
        check("rst_score", score, 0);
        rst = 0;

        // start -> launch pulse with a fresh duck
        cyc(0, 1, 0, 0, 0);
        check("t1_launch", duck_launch, 1);
        check("t1_shots", shots_left, 3);
        cyc(0, 0, 0, 0, 0);
        check("t1_launch_end", duck_launch, 0);

        // trigger and hit together
        cyc(0, 0, 1, 1, 0);
        check("t2_falling", duck_falling, 1);
        check("t2_hits", hits, 1);
        check("t2_score", score, 100);
        check("t2_shots", shots_left, 2);
        cyc(0, 0, 0, 0, 1);
        repeat (PAUSE - 1) cyc(1, 0, 0, 0, 0);
        check("t2_pause_hold", duck_launch, 0);
        cyc(1, 0, 0, 0, 0);
        check("t2_next_launch", duck_launch, 1);
        check("t2_idx", duck_idx, 1);

        // three misses then escape; a fourth trigger changes nothing
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0); check("t3_shot1", shots_left, 2);
        cyc(0, 0, 1, 0, 0); check("t3_shot2", shots_left, 1);
        cyc(0, 0, 1, 0, 0); check("t3_shot3", shots_left, 0);
        check("t3_fly_away", duck_fly_away, 1);
        cyc(0, 0, 1, 0, 0); check("t3_shot4", shots_left, 0);
        cyc(0, 0, 0, 0, 1);
        repeat (PAUSE) cyc(1, 0, 0, 0, 0);
        check("t3_idx", duck_idx, 2);

        // fly-away timeout, then hit coinciding with the timeout frame
        cyc(0, 0, 0, 0, 0);
        repeat (FLY - 1) cyc(1, 0, 0, 0, 0);
        check("t4_before_timeout", duck_fly_away, 0);
        cyc(1, 0, 0, 0, 0);
        check("t4_timeout", duck_fly_away, 1);
        cyc(0, 0, 0, 0, 1);
        repeat (PAUSE) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (FLY - 1) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        check("t4_tie_falling", duck_falling, 1);
        check("t4_tie_fly_away", duck_fly_away, 0);
        check("t4_tie_hits", hits, 2);

        // finish the round with misses: 2 hits is not enough
        for (int i = 0; i < 20000 && m_phase != M_OVER; i++) drive(0);
        check("t5_game_over", game_over, 1);
        check("t5_over_hits", hits, 2);
        cyc(0, 1, 0, 0, 0);
        check("t5_to_idle", game_over, 0);
        check("t5_idle_score", score, 200);
        cyc(0, 1, 0, 0, 0);
        check("t5_restart_launch", duck_launch, 1);
        check("t5_restart_score", score, 0);

        // hit every duck until the score saturates
        for (int i = 0; i < 70000 && m_score != 65535; i++) drive(1);
        check("t6_score_sat", score, 16'hFFFF);
        check("t6_round_sat", round_no, 15);
        repeat (300) drive(1);
        check("t6_score_held", score, 16'hFFFF);

        // reset in the middle of a flight
        for (int i = 0; i < 500 && m_phase != M_FLY; i++) drive(1);
        check("t6_in_fly", int'(m_phase == M_FLY), 1);
        rst = 1; new_frame = 1; start = 0; trigger = 0; duck_hit = 0; duck_offscreen = 0;
        step();
        check("t6_rst_round", round_no, 1);
        check("t6_rst_score", score, 0);
        check("t6_rst_shots", shots_left, 0);
        check("t6_rst_hits", hits, 0);
        rst = 0;

        repeat (10000) drive(2);
        check("cov_round2", seen_round2, 1);
        check("cov_game_over", seen_over, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
